// File: rtl/riscv32_dcache.sv
// riscv32_dcache: direct-mapped, write-back, write-allocate data cache.
// One-word lines, combinational hits, req/ack backing-memory refill and flush.
module riscv32_dcache #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_cache_rden,
    input  logic        d_cache_wren,
    input  logic [31:0] d_cache_rdwraddr,
    input  logic [3:0]  d_cache_wr_be,
    input  logic [31:0] d_cache_wrdata,
    output logic        d_cache_rdwrhit,
    output logic [31:0] d_cache_rddata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rddata,
    input  logic        flush_req,
    output logic        flush_done
);

    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        miss_q, miss_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wrdata_q, mem_wrdata_d;
    logic               flush_done_q, flush_done_d;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             req;
    logic             hit;
    logic [31:0]      merged;

    logic             dat_we;
    logic [IDX_W-1:0] dat_idx;
    logic [31:0]      dat_val;
    logic             tag_we;

    // Byte offset bits never select anything in a word-line cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^d_cache_rdwraddr[1:0];

    assign idx      = d_cache_rdwraddr[IDX_W+1:2];
    assign tag      = d_cache_rdwraddr[31:IDX_W+2];
    assign miss_idx = miss_q[IDX_W-1:0];
    assign miss_tag = miss_q[29:IDX_W];
    assign req      = d_cache_rden | d_cache_wren;

    // Zero-latency lookup and byte merge for write hits.
    always_comb begin
        hit = (state_q == IDLE) && req && valid_q[idx] && (tag_q[idx] == tag);
        d_cache_rdwrhit = hit;
        d_cache_rddata  = hit ? data_q[idx] : 32'h0;
        merged = data_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (d_cache_wr_be[i]) merged[8*i +: 8] = d_cache_wrdata[8*i +: 8];
        end
    end

    // Line state updates: write hits, fill install, dirty clears on write-back.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        dat_we  = 1'b0;
        dat_idx = idx;
        dat_val = merged;
        tag_we  = 1'b0;
        if (hit && d_cache_wren) begin
            dat_we       = 1'b1;
            dirty_d[idx] = 1'b1;
        end
        unique case (state_q)
            EVICT: if (mem_ack) dirty_d[miss_idx] = 1'b0;
            FILL: begin
                if (mem_ack) begin
                    dat_we            = 1'b1;
                    dat_idx           = miss_idx;
                    dat_val           = mem_rddata;
                    tag_we            = 1'b1;
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                end
            end
            FLUSH_WB: if (mem_ack) dirty_d[cnt_q] = 1'b0;
            default: ;
        endcase
    end

    // Miss / flush sequencer next-state and registered bus outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_d       = miss_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wrdata_d = mem_wrdata_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH_SCAN;
                    cnt_d   = '0;
                end else if (req && !hit) begin
                    miss_d    = d_cache_rdwraddr[31:2];
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d      = EVICT;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = {tag_q[idx], idx, 2'b00};
                        mem_wrdata_d = data_q[idx];
                    end else begin
                        state_d    = FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {d_cache_rdwraddr[31:2], 2'b00};
                    end
                end
            end
            EVICT: begin
                if (mem_ack) begin
                    state_d    = FILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {miss_q, 2'b00};
                end
            end
            FILL: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            FLUSH_SCAN: begin
                if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
                    state_d      = FLUSH_WB;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = {tag_q[cnt_q], cnt_q, 2'b00};
                    mem_wrdata_d = data_q[cnt_q];
                end else if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (cnt_q == LAST) begin
                        state_d      = IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = FLUSH_SCAN;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and bus output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            miss_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_q       <= miss_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Valid and dirty bits are the only storage that needs a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays, single write port each.
    always_ff @(posedge clk) begin
        if (!rst && dat_we) data_q[dat_idx] <= dat_val;
        if (!rst && tag_we) tag_q[miss_idx] <= miss_tag;
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wrdata = mem_wrdata_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_riscv32_dcache.sv
// tb_riscv32_dcache: directed checks of hits, misses, eviction, flush, reset.
// Memory side is answered by hand from the stimulus flow.
module tb_riscv32_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rden, wren;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rdwrhit;
    logic [31:0] rddata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wrdata;
    logic        mem_ack;
    logic [31:0] mem_rddata;
    logic        flush_req, flush_done;

    int total = 0;
    int bad   = 0;
    int n, reqs;

    riscv32_dcache dut (
        .clk              (clk),
        .rst              (rst),
        .d_cache_rden     (rden),
        .d_cache_wren     (wren),
        .d_cache_rdwraddr (addr),
        .d_cache_wr_be    (be),
        .d_cache_wrdata   (wd),
        .d_cache_rdwrhit  (rdwrhit),
        .d_cache_rddata   (rddata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wrdata       (mem_wrdata),
        .mem_ack          (mem_ack),
        .mem_rddata       (mem_rddata),
        .flush_req        (flush_req),
        .flush_done       (flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int lat, input logic [31:0] rdat,
                         input logic ewe, input logic [31:0] eaddr,
                         input logic [31:0] ewd);
        int k = 0;
        while (!mem_req && k < 50) begin
            cyc();
            k++;
        end
        chk("mem_req_seen", {31'h0, mem_req}, 32'h1);
        if (!mem_req) return;
        chk("mem_we", {31'h0, mem_we}, {31'h0, ewe});
        chk("mem_addr", mem_addr, eaddr);
        if (ewe) chk("mem_wrdata", mem_wrdata, ewd);
        for (int i = 0; i < lat; i++) begin
            cyc();
            chk("mem_hold", {31'h0, mem_req}, 32'h1);
            chk("addr_hold", mem_addr, eaddr);
        end
        mem_ack    = 1'b1;
        mem_rddata = rdat;
        cyc();
        mem_ack    = 1'b0;
        mem_rddata = 32'h0;
    endtask

    task automatic wait_done(output int cycles, output int nreq);
        cycles = 0;
        nreq   = 0;
        do begin
            cyc();
            cycles++;
            if (mem_req) nreq++;
        end while (!flush_done && cycles < 200);
        chk("flush_done", {31'h0, flush_done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rden = 0; wren = 0; addr = 0; be = 0; wd = 0;
        mem_ack = 0; mem_rddata = 0; flush_req = 0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_done", {31'h0, flush_done}, 32'h0);

        // cold read
        rden = 1; addr = 32'h104;
        #1;
        chk("cold_miss", {31'h0, rdwrhit}, 32'h0);
        chk("miss_rddata", rddata, 32'h0);
        cyc();
        serve(3, 32'hDEADBEEF, 1'b0, 32'h104, 32'h0);
        chk("fill_hit", {31'h0, rdwrhit}, 32'h1);
        chk("fill_data", rddata, 32'hDEADBEEF);
        chk("req_drop", {31'h0, mem_req}, 32'h0);
        cyc();
        chk("rehit", {31'h0, rdwrhit}, 32'h1);

        // write hit byte merge
        rden = 0; wren = 1; be = 4'b0010; wd = 32'h0000_5500;
        #1;
        chk("wr_hit", {31'h0, rdwrhit}, 32'h1);
        cyc();
        wren = 0; rden = 1;
        #1;
        chk("merge", rddata, 32'hDEAD55EF);

        // dirty eviction, back-to-back fill
        addr = 32'h204;
        #1;
        chk("evict_miss", {31'h0, rdwrhit}, 32'h0);
        cyc();
        serve(2, 32'h0, 1'b1, 32'h104, 32'hDEAD55EF);
        chk("b2b_req", {31'h0, mem_req}, 32'h1);
        chk("b2b_we", {31'h0, mem_we}, 32'h0);
        chk("b2b_addr", mem_addr, 32'h204);
        serve(1, 32'h1234_5678, 1'b0, 32'h204, 32'h0);
        chk("evict_hit", {31'h0, rdwrhit}, 32'h1);
        chk("evict_data", rddata, 32'h1234_5678);
        rden = 0;

        // make lines 3 and 10 dirty via write misses
        wren = 1; be = 4'hF; wd = 32'h3333_3333; addr = 32'h00C;
        cyc();
        serve(1, 32'h0, 1'b0, 32'h00C, 32'h0);
        chk("wmiss3_hit", {31'h0, rdwrhit}, 32'h1);
        cyc();
        wd = 32'hAAAA_AAAA; addr = 32'h028;
        cyc();
        serve(1, 32'h0, 1'b0, 32'h028, 32'h0);
        chk("wmiss10_hit", {31'h0, rdwrhit}, 32'h1);
        cyc();
        wren = 0;

        // flush with two dirty lines
        flush_req = 1;
        cyc();
        flush_req = 0;
        serve(1, 32'h0, 1'b1, 32'h00C, 32'h3333_3333);
        serve(1, 32'h0, 1'b1, 32'h028, 32'hAAAA_AAAA);
        wait_done(n, reqs);
        chk("flush1_cycles", n, 32'd53);
        chk("flush1_noreq", reqs, 32'd0);
        cyc();
        chk("done_pulse", {31'h0, flush_done}, 32'h0);

        // clean flush: pure scan
        flush_req = 1;
        cyc();
        flush_req = 0;
        wait_done(n, reqs);
        chk("flush2_cycles", n, 32'd64);
        chk("flush2_noreq", reqs, 32'd0);

        // lines still valid, now clean
        rden = 1; addr = 32'h00C;
        #1;
        chk("post_flush_hit", {31'h0, rdwrhit}, 32'h1);
        chk("post_flush_data", rddata, 32'h3333_3333);
        addr = 32'h10C;
        cyc();
        serve(1, 32'h55, 1'b0, 32'h10C, 32'h0);
        chk("clean_fill_hit", {31'h0, rdwrhit}, 32'h1);
        rden = 0;

        // dropped request still installs
        rden = 1; addr = 32'h300;
        cyc();
        rden = 0;
        serve(2, 32'h0BAD_F00D, 1'b0, 32'h300, 32'h0);
        chk("drop_nohit", {31'h0, rdwrhit}, 32'h0);
        rden = 1;
        #1;
        chk("drop_hit", {31'h0, rdwrhit}, 32'h1);
        chk("drop_data", rddata, 32'h0BAD_F00D);

        // reset during fill
        addr = 32'h400;
        cyc();
        chk("rfill_req", {31'h0, mem_req}, 32'h1);
        rden = 0; rst = 1;
        cyc();
        chk("rst_drop", {31'h0, mem_req}, 32'h0);
        rst = 0;
        mem_ack = 1; mem_rddata = 32'hFFFF_FFFF;
        cyc();
        mem_ack = 0; mem_rddata = 0;
        cyc();
        chk("late_ack", {31'h0, mem_req}, 32'h0);
        rden = 1; addr = 32'h300;
        #1;
        chk("inv_300", {31'h0, rdwrhit}, 32'h0);
        addr = 32'h00C;
        #1;
        chk("inv_00c", {31'h0, rdwrhit}, 32'h0);
        cyc();
        serve(1, 32'h0, 1'b0, 32'h00C, 32'h0);
        rden = 0;

        // simultaneous rden & wren miss -> write after fill
        rden = 1; wren = 1; be = 4'b0001; wd = 32'h0000_00AA; addr = 32'h500;
        cyc();
        serve(1, 32'h1122_3344, 1'b0, 32'h500, 32'h0);
        chk("rw_hit", {31'h0, rdwrhit}, 32'h1);
        chk("rw_rddata", rddata, 32'h1122_3344);
        cyc();
        wren = 0;
        #1;
        chk("rw_merge", rddata, 32'h1122_33AA);
        addr = 32'h600;
        cyc();
        serve(1, 32'h0, 1'b1, 32'h500, 32'h1122_33AA);
        serve(1, 32'h6666_6666, 1'b0, 32'h600, 32'h0);
        chk("rw_evict_hit", rddata, 32'h6666_6666);
        rden = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv32_dcache.md
Name: riscv32_dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache: the responder behind the engine's d-cache port (rden/wren/rdwraddr/wr_be/wrdata in, rdwrhit/rddata out).
- Hits are resolved combinationally in the same cycle as the request.
- Misses stall the requester: the cache keeps rdwrhit low while it evicts and refills over a simple req/ack backing-memory bus.
- A flush sequencer writes all dirty lines back to memory on demand.

Parameters:
- NUM_LINES, 64, number of one-word lines; power of two, minimum 2.
- IDX_W, $clog2(NUM_LINES), index width; index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- d_cache_rden  in  1  read request; held until hit.
- d_cache_wren  in  1  write request; held until hit.
- d_cache_rdwraddr  in  32  byte address; bits [1:0] ignored.
- d_cache_wr_be  in  4  byte enables for the write.
- d_cache_wrdata  in  32  write data.
- d_cache_rdwrhit  out  1  request served this cycle.
- d_cache_rddata  out  32  read data, valid when rdwrhit=1 and rden=1.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  1 = write-back, 0 = fill read.
- mem_addr  out  32  word-aligned address.
- mem_wrdata  out  32  eviction data.
- mem_ack  in  1  one-cycle completion pulse; mem_rddata valid with it.
- mem_rddata  in  32  fill data.
- flush_req  in  1  level; starts a flush when sampled high in IDLE.
- flush_done  out  1  one-cycle pulse when the flush completes.

Behaviour:
- Storage: per line valid, dirty, tag[31-IDX_W-2:0], data[31:0].
- Reset clears all valid and dirty bits. Tags and data are don't-care.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wrdata=0, flush_done=0.
- req = rden | wren. If both are high, the request is a write; rddata is still driven.
- hit = (state==IDLE) & req & valid[idx] & (tag[idx]==addr tag). This is combinational, zero latency.
- rdwrhit = hit.
- rddata = data[idx] when hit, else 32'h0.
- Write hit: on the same clock edge, merge bytes where wr_be[i]=1 into data[idx] and set dirty[idx]. wr_be=0 still counts as a hit; data is unchanged and dirty is set.
- FSM states: IDLE, EVICT, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, req and no hit, victim valid & dirty -> EVICT:
  - mem_req=1, mem_we=1, mem_addr={tag[idx],idx,2'b00}, mem_wrdata=data[idx].
- IDLE, req and no hit, victim clean or invalid -> FILL:
  - mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}.
- EVICT, mem_ack -> FILL: clear dirty[idx], issue the fill for the captured miss address.
- FILL, mem_ack: write data=mem_rddata, tag, valid=1, dirty=0, then -> IDLE, mem_req=0.
  - The held request hits the next cycle, giving a clean-miss read penalty of 2 + memory latency.
  - A write then merges on that hit cycle.
- Miss address and index are captured at IDLE exit. A request dropped or changed mid-miss does not abort the fill; the captured line is still installed.
- The mem_req/mem_we/mem_addr/mem_wrdata outputs are registered and stable while mem_req=1.
- mem_req drops in the cycle after mem_ack. A new request may be issued that same cycle (EVICT->FILL back-to-back: mem_req stays 1 and address/we change).
- Flush: flush_req in IDLE takes priority over a same-cycle miss; a same-cycle hit is still served. The FSM enters FLUSH_SCAN with counter=0.
- FLUSH_SCAN, each cycle:
  - if valid&dirty[counter] -> FLUSH_WB, issue the write-back;
  - else, if counter==NUM_LINES-1 -> IDLE and pulse flush_done;
  - else counter+1.
- FLUSH_WB, mem_ack: clear dirty[counter], then:
  - if last line -> IDLE, flush_done;
  - else counter+1 -> FLUSH_SCAN.
- Lines remain valid after a flush.
- No hits are reported outside IDLE.
- rst asserted mid-miss or mid-flush returns to reset state immediately. mem_req drops the next cycle; an outstanding mem_ack arriving later is ignored.
- mem_ack received in IDLE or FLUSH_SCAN is ignored.

Test Plan:
- Cold read: reset, then rden=1 at addr 0x0000_0104 and mem returns 0xDEADBEEF after 3 cycles.
  - Expect one FILL request at mem_addr=0x104 with mem_we=0.
  - Expect rdwrhit=1 with rddata=0xDEADBEEF on the cycle after mem_ack; a repeat read hits with zero latency.
- Write hit byte merge: line 0x104 holds 0xDEADBEEF; write wr_be=4'b0010, wrdata=0x0000_5500.
  - Expect same-cycle hit; the following read returns 0xDEAD55EF.
- Dirty eviction: dirty 0x104 (0xDEAD55EF), then read 0x0000_0204 (same index 1, different tag).
  - Expect EVICT with mem_we=1, addr 0x104, data 0xDEAD55EF.
  - Then FILL at 0x204, back-to-back with mem_req held high; then a hit.
- Flush: lines 3 and 10 dirty, assert flush_req.
  - Expect exactly two write-backs, in index order 3 then 10, then a single flush_done pulse.
  - A second flush produces no mem traffic and flush_done after 64 scan cycles.
- Dropped request and reset: start a miss at 0x300, deassert rden while in FILL, and ack.
  - Expect the line installed valid; a later read of 0x300 hits.
  - Repeat with rst during FILL: expect mem_req=0 next cycle, all lines invalid, and a late mem_ack ignored.
- Simultaneous rden & wren on a miss: expect the request handled as a write after the fill, with the line dirty.
